core_bus_arbiter: RTL and testbench
===================================

Name: core_bus_arbiter

Overview:
Sits directly downstream of the core, between its instruction bus (ireq/iresp) and data bus (dreq/dresp) and a single shared memory port. It arbitrates between the two buses and holds the winning request on the memory port until the memory responds. It then returns a registered, one-cycle data_ok to the requester. A watchdog counter terminates hung transactions with an error flag.

Parameters:
TIMEOUT_CYC, 1024, max cycles waiting for mresp_ready before forced completion; 0 disables the watchdog
ADDR_W, 64, address width of all buses

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous reset, active-low (asserted when 0)
ireq_valid  in  1  instruction fetch request
ireq_addr  in  ADDR_W  fetch address (4-byte aligned)
iresp_addr_ok  out  1  fetch request accepted (grant cycle)
iresp_data_ok  out  1  fetch data valid, one-cycle pulse
iresp_data  out  32  fetched instruction
dreq_valid  in  1  data request
dreq_addr  in  ADDR_W  data address
dreq_size  in  3  log2 bytes (0..3)
dreq_strobe  in  8  byte write enables; 0 = read
dreq_data  in  64  write data
dresp_addr_ok  out  1  data request accepted (grant cycle)
dresp_data_ok  out  1  data response, one-cycle pulse
dresp_data  out  64  read data
mreq_valid  out  1  memory request valid
mreq_is_write  out  1  1 when captured strobe != 0
mreq_addr  out  ADDR_W  memory address
mreq_size  out  3  access size (instruction = 3'd2)
mreq_strobe  out  8  byte enables
mreq_data  out  64  write data
mresp_ready  in  1  memory completes current request this cycle
mresp_data  in  64  memory read data, valid with mresp_ready
err  out  1  sticky watchdog-timeout flag

Behaviour:
- Reset (reset==0, async): state IDLE; all outputs 0; watchdog counter 0; err cleared; rr_flag 0.
- States: IDLE, I_WAIT, D_WAIT, I_DONE, D_DONE.
- IDLE grant:
  - Only dreq_valid: grant D.
  - Only ireq_valid: grant I.
  - Both valid: grant D unless rr_flag==1, then grant I.
  - Grant is combinational in the same cycle: the matching *_addr_ok=1, the request fields are captured into registers, and the next state is x_WAIT.
  - No request: stay IDLE.
- rr_flag: set to 1 when a D grant occurs while ireq_valid is high; cleared on any I grant. This prevents fetch starvation.
- x_WAIT:
  - mreq_valid=1; mreq_* are driven only from the captured registers. Upstream changes after grant have no effect.
  - I capture: mreq_size=3'd2, strobe 0, is_write 0, data 0.
  - On mresp_ready: register the response data and go to x_DONE.
  - mresp_data is ignored when the captured request is a write, and dresp_data is then 0.
- x_DONE: matching *_data_ok=1 for exactly this cycle with the registered data; mreq_valid=0; next state IDLE. Any request is granted at the earliest in the following IDLE cycle.
- Response latency: request granted in cycle T with mresp_ready in cycle T+k (k>=1) gives data_ok in cycle T+k+1. Minimum grant-to-data_ok is 2 cycles. Back-to-back grants are 3 cycles apart (IDLE, WAIT, DONE).
- iresp_data: mresp_data[63:32] when captured addr[2]==1, else mresp_data[31:0].
- Watchdog:
  - The counter increments each cycle in x_WAIT and clears on leaving x_WAIT.
  - If TIMEOUT_CYC!=0 and the counter reaches TIMEOUT_CYC-1 without mresp_ready: go to x_DONE with data 0 and set err.
  - err stays set until reset.
  - mresp_ready in the same cycle as timeout wins: normal data, err not set.
- A requester that drops valid during WAIT still receives its data_ok; upstream is responsible for discarding it.
- mresp_ready in IDLE or DONE is ignored.
- Reset mid-transaction returns to IDLE immediately. mreq_valid drops asynchronously, and no data_ok is issued for the aborted request.

Test Plan:
- Only ireq_valid, addr=0x8000_0004; mresp_ready 3 cycles after grant with data=0x1111_2222_3333_4444 -> iresp_addr_ok at T, iresp_data_ok at T+4, iresp_data=0x1111_2222, mreq_size=2.
- ireq_valid and dreq_valid both high, rr_flag=0 -> D granted first (dresp_addr_ok); the following IDLE cycle grants I even though dreq is still valid.
- dreq write, addr=0x100, strobe=0x0F, data=0xDEAD_BEEF, size=2 -> mreq_is_write=1, fields held while dreq_addr is changed upstream during WAIT; dresp_data_ok pulses once with dresp_data=0.
- TIMEOUT_CYC=8, mresp_ready never asserted -> data_ok 9 cycles after grant, data 0, err=1 until reset.
- mresp_ready asserted in the same cycle as timeout -> normal data returned, err stays 0.
- reset driven low in D_WAIT -> mreq_valid=0 immediately, no dresp_data_ok; after reset returns high, a new ireq is granted normally.

Source files
------------

// File: rtl/core_bus_arbiter_if.sv
// Core fetch/data buses and the shared memory port around core_bus_arbiter.
// slave is the arbiter's view; master is the view of whatever drives it.
interface core_bus_arbiter_if #(
  parameter int ADDR_W = 64
);
  logic              ireq_valid;
  logic [ADDR_W-1:0] ireq_addr;
  logic              iresp_addr_ok;
  logic              iresp_data_ok;
  logic [31:0]       iresp_data;

  logic              dreq_valid;
  logic [ADDR_W-1:0] dreq_addr;
  logic [2:0]        dreq_size;
  logic [7:0]        dreq_strobe;
  logic [63:0]       dreq_data;
  logic              dresp_addr_ok;
  logic              dresp_data_ok;
  logic [63:0]       dresp_data;

  logic              mreq_valid;
  logic              mreq_is_write;
  logic [ADDR_W-1:0] mreq_addr;
  logic [2:0]        mreq_size;
  logic [7:0]        mreq_strobe;
  logic [63:0]       mreq_data;
  logic              mresp_ready;
  logic [63:0]       mresp_data;

  logic              err;

  modport slave (
    input  ireq_valid, ireq_addr,
    output iresp_addr_ok, iresp_data_ok, iresp_data,
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    output mreq_valid, mreq_is_write, mreq_addr, mreq_size, mreq_strobe, mreq_data,
    input  mresp_ready, mresp_data,
    output err
  );

  modport master (
    output ireq_valid, ireq_addr,
    input  iresp_addr_ok, iresp_data_ok, iresp_data,
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    input  mreq_valid, mreq_is_write, mreq_addr, mreq_size, mreq_strobe, mreq_data,
    output mresp_ready, mresp_data,
    input  err
  );
endinterface

// File: rtl/core_bus_arbiter.sv
// Arbitrates the core's fetch and data buses onto one memory port and holds each
// request until memory answers or the watchdog forces completion.
module core_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int          ADDR_W      = 64
) (
  input logic               clk,
  input logic               reset,
  core_bus_arbiter_if.slave bus
);
  // state  | meaning
  // IDLE   | no transaction; arbitrate and grant this cycle
  // I_WAIT | fetch held on the memory port
  // D_WAIT | data request held on the memory port
  // I_DONE | iresp_data_ok pulse
  // D_DONE | dresp_data_ok pulse
  typedef enum logic [2:0] {IDLE, I_WAIT, D_WAIT, I_DONE, D_DONE} state_t;

  localparam int unsigned CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned WD_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
  localparam logic [CNT_W-1:0] WD_TC = CNT_W'(WD_LAST);

  state_t            state;
  logic              rr_flag;
  logic [CNT_W-1:0]  wd_cnt;
  logic              grant_i, grant_d, wd_expire;

  logic              mreq_valid_q, mreq_is_write_q;
  logic [ADDR_W-1:0] cap_addr;
  logic [2:0]        cap_size;
  logic [7:0]        cap_strobe;
  logic [63:0]       cap_data;
  logic              iresp_ok_q, dresp_ok_q;
  logic [31:0]       iresp_data_q;
  logic [63:0]       dresp_data_q;
  logic              err_q;

  // rr_flag hands a contested IDLE cycle to the fetch side after a data win.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
      if (bus.dreq_valid && !(bus.ireq_valid && rr_flag))
        grant_d = 1'b1;
      else if (bus.ireq_valid)
        grant_i = 1'b1;
    end
  end

  assign wd_expire = (TIMEOUT_CYC != 0) && (wd_cnt == WD_TC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      rr_flag         <= 1'b0;
      wd_cnt          <= '0;
      mreq_valid_q    <= 1'b0;
      mreq_is_write_q <= 1'b0;
      cap_addr        <= '0;
      cap_size        <= '0;
      cap_strobe      <= '0;
      cap_data        <= '0;
      iresp_ok_q      <= 1'b0;
      dresp_ok_q      <= 1'b0;
      iresp_data_q    <= '0;
      dresp_data_q    <= '0;
      err_q           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (grant_d) begin
            state           <= D_WAIT;
            mreq_valid_q    <= 1'b1;
            mreq_is_write_q <= |bus.dreq_strobe;
            cap_addr        <= bus.dreq_addr;
            cap_size        <= bus.dreq_size;
            cap_strobe      <= bus.dreq_strobe;
            cap_data        <= bus.dreq_data;
            if (bus.ireq_valid)
              rr_flag <= 1'b1;
          end else if (grant_i) begin
            state           <= I_WAIT;
            mreq_valid_q    <= 1'b1;
            mreq_is_write_q <= 1'b0;
            cap_addr        <= bus.ireq_addr;
            cap_size        <= 3'd2;
            cap_strobe      <= '0;
            cap_data        <= '0;
            rr_flag         <= 1'b0;
          end
        end
        I_WAIT, D_WAIT: begin
          if (bus.mresp_ready || wd_expire) begin
            mreq_valid_q <= 1'b0;
            wd_cnt       <= '0;
            if (!bus.mresp_ready)
              err_q <= 1'b1;
            if (state == I_WAIT) begin
              state      <= I_DONE;
              iresp_ok_q <= 1'b1;
              if (!bus.mresp_ready)
                iresp_data_q <= '0;
              else if (cap_addr[2])
                iresp_data_q <= bus.mresp_data[63:32];
              else
                iresp_data_q <= bus.mresp_data[31:0];
            end else begin
              state        <= D_DONE;
              dresp_ok_q   <= 1'b1;
              dresp_data_q <= (bus.mresp_ready && !mreq_is_write_q) ? bus.mresp_data : 64'h0;
            end
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        I_DONE, D_DONE: begin
          state      <= IDLE;
          iresp_ok_q <= 1'b0;
          dresp_ok_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.iresp_addr_ok = grant_i;
  assign bus.dresp_addr_ok = grant_d;
  assign bus.iresp_data_ok = iresp_ok_q;
  assign bus.iresp_data    = iresp_data_q;
  assign bus.dresp_data_ok = dresp_ok_q;
  assign bus.dresp_data    = dresp_data_q;
  assign bus.mreq_valid    = mreq_valid_q;
  assign bus.mreq_is_write = mreq_is_write_q;
  assign bus.mreq_addr     = cap_addr;
  assign bus.mreq_size     = cap_size;
  assign bus.mreq_strobe   = cap_strobe;
  assign bus.mreq_data     = cap_data;
  assign bus.err           = err_q;
endmodule

// File: tb/tb_core_bus_arbiter.sv
// Vector table, directed corner sequences and a randomized run against a
// transaction-level model of the arbiter.
module tb_core_bus_arbiter;
  localparam int TO = 8;
  localparam int AW = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core_bus_arbiter_if #(.ADDR_W(AW)) bus ();
  core_bus_arbiter #(.TIMEOUT_CYC(TO), .ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.ireq_valid  = 1'b0;
    bus.ireq_addr   = '0;
    bus.dreq_valid  = 1'b0;
    bus.dreq_addr   = '0;
    bus.dreq_size   = '0;
    bus.dreq_strobe = '0;
    bus.dreq_data   = '0;
    bus.mresp_ready = 1'b0;
    bus.mresp_data  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic iv; logic [63:0] ia; logic dv; logic [63:0] da; logic [2:0] dsz;
    logic [7:0] dst; logic [63:0] dd; logic mr; logic [63:0] md;
    logic xia; logic xda; logic xio; logic xdo; logic xmv; logic xmw;
    logic [63:0] xma; logic [2:0] xmsz; logic [7:0] xmst; logic [63:0] xmd;
    logic [31:0] xid; logic [63:0] xdd;
  } vec_t;

  vec_t tbl[18];

  task automatic run_random(input int ncyc, input int rdy_pct);
    bit m_busy, m_resp, m_is_i, m_rr, m_err;
    int m_k;
    logic [63:0] m_addr, m_data, m_rdata;
    logic [2:0]  m_size;
    logic [7:0]  m_strb;
    bit e_i, e_d;
    m_busy = 0; m_resp = 0; m_is_i = 0; m_rr = 0; m_err = 0; m_k = 0;
    m_addr = '0; m_data = '0; m_rdata = '0; m_size = '0; m_strb = '0;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      bus.ireq_valid  = ($urandom_range(0, 99) < 45);
      bus.ireq_addr   = {$urandom, $urandom} & ~64'h3;
      bus.dreq_valid  = ($urandom_range(0, 99) < 45);
      bus.dreq_addr   = {$urandom, $urandom};
      bus.dreq_size   = 3'($urandom_range(0, 3));
      bus.dreq_strobe = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      bus.dreq_data   = {$urandom, $urandom};
      bus.mresp_ready = ($urandom_range(0, 99) < rdy_pct);
      bus.mresp_data  = {$urandom, $urandom};
      #1;
      // Who wins if the port is free: a lone requester, else D unless a fetch is owed.
      e_i = 0; e_d = 0;
      if (!m_busy && !m_resp) begin
        if (bus.ireq_valid && bus.dreq_valid) begin
          if (m_rr) e_i = 1; else e_d = 1;
        end else begin
          e_i = bus.ireq_valid;
          e_d = bus.dreq_valid;
        end
      end
      check("rnd iaok", 64'(bus.iresp_addr_ok), 64'(e_i));
      check("rnd daok", 64'(bus.dresp_addr_ok), 64'(e_d));
      check("rnd idok", 64'(bus.iresp_data_ok), 64'(m_resp && m_is_i));
      check("rnd ddok", 64'(bus.dresp_data_ok), 64'(m_resp && !m_is_i));
      check("rnd mvalid", 64'(bus.mreq_valid), 64'(m_busy));
      check("rnd err", 64'(bus.err), 64'(m_err));
      if (m_busy) begin
        check("rnd maddr", bus.mreq_addr, m_addr);
        check("rnd msize", 64'(bus.mreq_size), 64'(m_size));
        check("rnd mstrb", 64'(bus.mreq_strobe), 64'(m_strb));
        check("rnd mdata", bus.mreq_data, m_data);
        check("rnd mwr", 64'(bus.mreq_is_write), 64'(m_strb != 0));
      end
      if (m_resp && m_is_i) check("rnd idata", 64'(bus.iresp_data), m_rdata);
      if (m_resp && !m_is_i) check("rnd ddata", bus.dresp_data, m_rdata);
      // advance the model across the clock edge
      if (m_resp) begin
        m_resp = 0;
      end else if (m_busy) begin
        m_k++;
        if (bus.mresp_ready) begin
          m_busy = 0; m_resp = 1;
          if (m_is_i) m_rdata = m_addr[2] ? {32'h0, bus.mresp_data[63:32]} : {32'h0, bus.mresp_data[31:0]};
          else m_rdata = (m_strb != 0) ? 64'h0 : bus.mresp_data;
        end else if (m_k == TO) begin
          m_busy = 0; m_resp = 1; m_rdata = '0; m_err = 1;
        end
      end else if (e_d) begin
        m_busy = 1; m_is_i = 0; m_k = 0;
        m_addr = bus.dreq_addr; m_size = bus.dreq_size; m_strb = bus.dreq_strobe; m_data = bus.dreq_data;
        if (bus.ireq_valid) m_rr = 1;
      end else if (e_i) begin
        m_busy = 1; m_is_i = 1; m_k = 0; m_rr = 0;
        m_addr = bus.ireq_addr; m_size = 3'd2; m_strb = '0; m_data = '0;
      end
    end
  endtask

  initial begin
    int lat;
    logic [63:0] got;

    tbl[0]  = '{1'b1,64'h8000_0004,1'b0,64'h0,3'd0,8'h00,64'h0,1'b0,64'h0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,64'h0,3'd0,8'h00,64'h0,32'h0,64'h0};
    tbl[1]  = '{1'b0,64'h0,1'b0,64'h0,3'd0,8'h00,64'h0,1'b0,64'h0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,64'h8000_0004,3'd2,8'h00,64'h0,32'h0,64'h0};
    tbl[2]  = tbl[1];
    tbl[3]  = '{1'b0,64'h0,1'b0,64'h0,3'd0,8'h00,64'h0,1'b1,64'h1111_2222_3333_4444, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,64'h8000_0004,3'd2,8'h00,64'h0,32'h0,64'h0};
    tbl[4]  = '{1'b0,64'h0,1'b0,64'h0,3'd0,8'h00,64'h0,1'b0,64'h0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,64'h0,3'd0,8'h00,64'h0,32'h1111_2222,64'h0};
    tbl[5]  = '{1'b0,64'h0,1'b0,64'h0,3'd0,8'h00,64'h0,1'b0,64'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,64'h0,3'd0,8'h00,64'h0,32'h0,64'h0};
    tbl[6]  = '{1'b1,64'h1000,1'b1,64'h2000,3'd3,8'h00,64'h0,1'b0,64'h0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,64'h0,3'd0,8'h00,64'h0,32'h0,64'h0};
    tbl[7]  = '{1'b1,64'h1000,1'b1,64'h2000,3'd3,8'h00,64'h0,1'b1,64'hAAAA_BBBB_CCCC_DDDD, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,64'h2000,3'd3,8'h00,64'h0,32'h0,64'h0};
    tbl[8]  = '{1'b1,64'h1000,1'b1,64'h2000,3'd3,8'h00,64'h0,1'b1,64'h9999_9999_9999_9999, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,64'h0,3'd0,8'h00,64'h0,32'h0,64'hAAAA_BBBB_CCCC_DDDD};
    tbl[9]  = '{1'b1,64'h1000,1'b1,64'h2000,3'd3,8'h00,64'h0,1'b0,64'h0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,64'h0,3'd0,8'h00,64'h0,32'h0,64'h0};
    tbl[10] = '{1'b0,64'h0,1'b1,64'h2000,3'd3,8'h00,64'h0,1'b1,64'h5555_6666_7777_8888, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,64'h1000,3'd2,8'h00,64'h0,32'h0,64'h0};
    tbl[11] = '{1'b0,64'h0,1'b1,64'h2000,3'd3,8'h00,64'h0,1'b0,64'h0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,64'h0,3'd0,8'h00,64'h0,32'h7777_8888,64'h0};
    tbl[12] = '{1'b0,64'h0,1'b1,64'h100,3'd2,8'h0F,64'hDEAD_BEEF,1'b0,64'h0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,64'h0,3'd0,8'h00,64'h0,32'h0,64'h0};
    tbl[13] = '{1'b0,64'h0,1'b1,64'h200,3'd3,8'hFF,64'h0,1'b0,64'h0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,64'h100,3'd2,8'h0F,64'hDEAD_BEEF,32'h0,64'h0};
    tbl[14] = '{1'b0,64'h0,1'b0,64'h200,3'd3,8'hFF,64'h0,1'b1,64'hFFFF_FFFF_FFFF_FFFF, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,64'h100,3'd2,8'h0F,64'hDEAD_BEEF,32'h0,64'h0};
    tbl[15] = '{1'b0,64'h0,1'b0,64'h0,3'd0,8'h00,64'h0,1'b0,64'h0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,64'h0,3'd0,8'h00,64'h0,32'h0,64'h0};
    tbl[16] = '{1'b0,64'h0,1'b0,64'h0,3'd0,8'h00,64'h0,1'b1,64'h1234,   1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,64'h0,3'd0,8'h00,64'h0,32'h0,64'h0};
    tbl[17] = tbl[5];

    drive_idle();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst mvalid", 64'(bus.mreq_valid), 64'h0);
    check("rst idok", 64'(bus.iresp_data_ok), 64'h0);
    check("rst ddok", 64'(bus.dresp_data_ok), 64'h0);
    check("rst err", 64'(bus.err), 64'h0);
    check("rst maddr", bus.mreq_addr, 64'h0);
    check("rst mdata", bus.mreq_data, 64'h0);
    check("rst idata", 64'(bus.iresp_data), 64'h0);
    check("rst ddata", bus.dresp_data, 64'h0);
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      bus.ireq_valid = tbl[i].iv;   bus.ireq_addr   = tbl[i].ia;
      bus.dreq_valid = tbl[i].dv;   bus.dreq_addr   = tbl[i].da;
      bus.dreq_size  = tbl[i].dsz;  bus.dreq_strobe = tbl[i].dst;
      bus.dreq_data  = tbl[i].dd;   bus.mresp_ready = tbl[i].mr;
      bus.mresp_data = tbl[i].md;
      #1;
      check($sformatf("row%0d iaok", i), 64'(bus.iresp_addr_ok), 64'(tbl[i].xia));
      check($sformatf("row%0d daok", i), 64'(bus.dresp_addr_ok), 64'(tbl[i].xda));
      check($sformatf("row%0d idok", i), 64'(bus.iresp_data_ok), 64'(tbl[i].xio));
      check($sformatf("row%0d ddok", i), 64'(bus.dresp_data_ok), 64'(tbl[i].xdo));
      check($sformatf("row%0d mvalid", i), 64'(bus.mreq_valid), 64'(tbl[i].xmv));
      check($sformatf("row%0d err", i), 64'(bus.err), 64'h0);
      if (tbl[i].xmv) begin
        check($sformatf("row%0d mwr", i), 64'(bus.mreq_is_write), 64'(tbl[i].xmw));
        check($sformatf("row%0d maddr", i), bus.mreq_addr, tbl[i].xma);
        check($sformatf("row%0d msize", i), 64'(bus.mreq_size), 64'(tbl[i].xmsz));
        check($sformatf("row%0d mstrb", i), 64'(bus.mreq_strobe), 64'(tbl[i].xmst));
        check($sformatf("row%0d mdata", i), bus.mreq_data, tbl[i].xmd);
      end
      if (tbl[i].xio) check($sformatf("row%0d idata", i), 64'(bus.iresp_data), 64'(tbl[i].xid));
      if (tbl[i].xdo) check($sformatf("row%0d ddata", i), bus.dresp_data, tbl[i].xdd);
    end

    // watchdog expiry: memory never answers
    @(negedge clk);
    drive_idle();
    bus.dreq_valid = 1'b1; bus.dreq_addr = 64'h300; bus.dreq_size = 3'd3;
    #1;
    check("to grant", 64'(bus.dresp_addr_ok), 64'h1);
    lat = -1; got = '1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      bus.dreq_valid = 1'b0;
      #1;
      if (bus.dresp_data_ok) begin lat = j; got = bus.dresp_data; break; end
    end
    check("to latency", 64'(lat), 64'd9);
    check("to data", got, 64'h0);
    check("to err", 64'(bus.err), 64'h1);
    repeat (3) @(negedge clk);
    #1;
    check("to err sticky", 64'(bus.err), 64'h1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("to err cleared", 64'(bus.err), 64'h0);
    @(negedge clk);
    reset = 1'b1;

    // mresp_ready on the timeout cycle wins
    @(negedge clk);
    bus.dreq_valid = 1'b1; bus.dreq_addr = 64'h400; bus.dreq_size = 3'd3; bus.dreq_strobe = 8'h00;
    #1;
    check("race grant", 64'(bus.dresp_addr_ok), 64'h1);
    lat = -1; got = '1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      bus.dreq_valid  = 1'b0;
      bus.mresp_ready = (j == TO);
      bus.mresp_data  = 64'hCAFE_F00D_1234_5678;
      #1;
      if (bus.dresp_data_ok) begin lat = j; got = bus.dresp_data; break; end
    end
    bus.mresp_ready = 1'b0;
    check("race latency", 64'(lat), 64'd9);
    check("race data", got, 64'hCAFE_F00D_1234_5678);
    check("race err", 64'(bus.err), 64'h0);

    // reset while a data request is outstanding
    @(negedge clk);
    bus.dreq_valid = 1'b1; bus.dreq_addr = 64'h500;
    #1;
    check("abort grant", 64'(bus.dresp_addr_ok), 64'h1);
    @(negedge clk);
    bus.dreq_valid = 1'b0;
    #1;
    check("abort mvalid pre", 64'(bus.mreq_valid), 64'h1);
    #1;
    reset = 1'b0;
    #1;
    check("abort mvalid async", 64'(bus.mreq_valid), 64'h0);
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      #1;
      check("abort no ddok", 64'(bus.dresp_data_ok), 64'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort no ddok after", 64'(bus.dresp_data_ok), 64'h0);
    @(negedge clk);
    bus.ireq_valid = 1'b1; bus.ireq_addr = 64'h600;
    #1;
    check("post-rst iaok", 64'(bus.iresp_addr_ok), 64'h1);
    @(negedge clk);
    bus.ireq_valid  = 1'b0;
    bus.mresp_ready = 1'b1;
    bus.mresp_data  = 64'h0BAD_0BAD_600D_600D;
    #1;
    check("post-rst maddr", bus.mreq_addr, 64'h600);
    @(negedge clk);
    bus.mresp_ready = 1'b0;
    #1;
    check("post-rst idok", 64'(bus.iresp_data_ok), 64'h1);
    check("post-rst idata", 64'(bus.iresp_data), 64'h600D_600D);

    run_random(1200, 60);
    run_random(1200, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
